rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

- Shares the single on-die RGB LED driver among several requesters.
- Each requester offers a 24-bit colour and a display duration in milliseconds.
- A round-robin arbiter grants one request at a time and shows that colour for the requested duration.
- The block produces the three PWM enables that feed the RGB driver's RGB0PWM/RGB1PWM/RGB2PWM inputs, clocked from the 48 MHz internal oscillator.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PWM_BITS, 8, PWM resolution per colour channel
- TICK_DIV, 48000, clk cycles per duration tick (1 ms at 48 MHz)
- DUR_BITS, 16, width of each duration field
- clk  in  1  oscillator clock (CLKHF net)
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe; transfer when valid&ready
- req_color  in  NUM_REQ*24  packed colour per requester, {R[23:16], G[15:8], B[7:0]}
- req_dur  in  NUM_REQ*DUR_BITS  packed duration in ticks per requester
- cancel  in  1  abort current display
- pwm_red / pwm_green / pwm_blue  out  1 each  PWM enables to RGB0PWM/RGB1PWM/RGB2PWM
- busy  out  1  high while in SHOW
- owner  out  clog2(NUM_REQ)  index of the granted requester; valid while busy

## Operation
- FSM has two states: IDLE and SHOW.
- **IDLE, requester selection**
  - The winner is the first i with req_valid[i], scanning from rr_ptr upward with wrap.
  - req_ready[winner] is high combinationally in the same cycle; all other req_ready bits are low.
  - No req_ready bit is high if cancel=1 or no request is valid.
- **IDLE, on transfer**
  - Latch that requester's colour into duty_r/g/b.
  - Set remaining = max(req_dur,1), so a duration of 0 is treated as 1.
  - Set owner = winner and rr_ptr = (winner+1) mod NUM_REQ.
  - Clear tick_cnt and pwm_cnt, then go to SHOW.
- **SHOW**
  - tick_cnt counts 0..TICK_DIV-1.
  - At wrap: if remaining==1, go to IDLE; otherwise remaining decrements.
  - cancel=1 forces IDLE next cycle. cancel also wins if it coincides with the final tick.
  - req_ready is all zero in SHOW.
- **PWM**
  - pwm_cnt is PWM_BITS wide, free-running in SHOW and wraps naturally.
  - Each output is registered: pwm_x = busy & (pwm_cnt < duty_x).
  - duty 0 gives the output constantly low; duty 255 gives 255 of every 256 cycles high. Full-on is never reached, by design.
- In IDLE, all pwm_* = 0, busy = 0 and owner holds its last value.
- Widths:
  - remaining and req_dur are DUR_BITS unsigned.
  - tick_cnt is clog2(TICK_DIV).
  - No saturation is needed beyond the zero-duration rule.

## Timing
- Reset values: state IDLE, rr_ptr=0, owner=0, busy=0, pwm_*=0, all counters 0, duties 0.
- Transfer in cycle N:
  - busy=1 from N+1.
  - pwm_x in cycle N+1+k equals ((k mod 2^PWM_BITS) < duty_x).
- A display of duration D (D≥1) keeps busy high for exactly D*TICK_DIV cycles, N+1 .. N+D*TICK_DIV. IDLE is entered at cycle N+1+D*TICK_DIV.
- Back-to-back: the next transfer can occur in the first IDLE cycle, giving one dark cycle between displays.
- cancel asserted in cycle M during SHOW: busy=0 and pwm_*=0 from M+1.
- rst during SHOW: all reset values from the next cycle. A request held across reset is re-arbitrated starting from index 0.
- A requester dropping req_valid while not granted has no effect.
- Once granted, the colour and duration are captured and later input changes are ignored.

## Structure
- Package rgb_led_pkg contains:
  - typedef rgb_color_t (three 8-bit fields r, g, b)
  - state enum {IDLE, SHOW}
  - localparam COLOR_W=24
- Sub-module rgb_pwm_gen:
  - Holds pwm_cnt, three comparators and the registered outputs.
  - Inputs: clk, rst, en, clr, duty_r/g/b.
  - Instantiated once.
- Arbiter, tick prescaler and FSM live in rgb_led_arbiter.
- For simulation, TICK_DIV is overridden to 4.

## Test plan
- **Single request:** TICK_DIV=4, req 0 valid with colour 0x80_00_FF and dur=3, transfer at N.
  - busy is high N+1..N+12.
  - pwm_red is high for the first 128 of each 256 cycles within the window, pwm_green is 0, pwm_blue is high for 255 of 256 cycles.
- **Round robin:** all 4 requesters held valid, dur=1 each.
  - Grants go 0,1,2,3,0 in order.
  - Each grant follows the previous IDLE entry with no extra gap.
- **Zero duration:** dur=0 is shown for exactly TICK_DIV cycles, the same as dur=1.
- **Cancel:**
  - cancel at the 2nd SHOW cycle gives busy=0 and pwm_*=0 on the next cycle.
  - cancel coinciding with the final tick also returns to IDLE.
  - cancel held in IDLE keeps req_ready=0.
- **Reset mid-show:** rst asserted in SHOW gives all outputs at reset values next cycle. The following grant goes to the lowest valid index.
- **Priority rotation:** after a grant to requester 2, with requesters 1 and 3 both valid, requester 3 is granted, then requester 1.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED arbiter: colour layout, FSM states and colour width.
package rgb_led_pkg;

  localparam int COLOR_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_color_t;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator: one free-running counter, three comparators, registered enables.
module rgb_pwm_gen
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [PWM_BITS-1:0] i_duty_r,
  input  logic [PWM_BITS-1:0] i_duty_g,
  input  logic [PWM_BITS-1:0] i_duty_b,
  output logic                o_pwm_r,
  output logic                o_pwm_g,
  output logic                o_pwm_b
);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_cnt_next;

  // i_en and duties describe the coming cycle, so compare against the next count value.
  always_comb begin
    w_cnt_next = r_pwm_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = r_pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      o_pwm_r   <= 1'b0;
      o_pwm_g   <= 1'b0;
      o_pwm_b   <= 1'b0;
    end else begin
      r_pwm_cnt <= w_cnt_next;
      o_pwm_r   <= i_en & (w_cnt_next < i_duty_r);
      o_pwm_g   <= i_en & (w_cnt_next < i_duty_g);
      o_pwm_b   <= i_en & (w_cnt_next < i_duty_b);
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin sharing of the single RGB LED driver: each granted requester's colour
// is shown as PWM for its requested number of ticks.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 48000,
  parameter int DUR_BITS = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*COLOR_W-1:0]    i_req_color,
  input  logic [NUM_REQ*DUR_BITS-1:0]   i_req_dur,
  input  logic                          i_cancel,
  output logic                          o_pwm_red,
  output logic                          o_pwm_green,
  output logic                          o_pwm_blue,
  output logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_owner
);

  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t              r_state;
  state_t              w_state_next;
  logic [OWN_W-1:0]    r_rr_ptr;
  logic [OWN_W-1:0]    r_owner;
  logic [OWN_W-1:0]    w_winner;
  logic                w_found;
  logic                w_transfer;
  logic                w_tick_wrap;
  logic                w_en_next;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [DUR_BITS-1:0] r_remaining;
  logic [DUR_BITS-1:0] w_in_dur;
  rgb_color_t          r_duty;
  rgb_color_t          w_in_color;
  rgb_color_t          w_duty_next;

  // First valid requester scanning upward from r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin : p_arb
    logic [OWN_W:0] sum;
    w_found  = 1'b0;
    w_winner = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_rr_ptr} + (OWN_W+1)'(k);
      if (sum >= (OWN_W+1)'(NUM_REQ)) begin
        sum = sum - (OWN_W+1)'(NUM_REQ);
      end
      if (!w_found && i_req_valid[sum[OWN_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = sum[OWN_W-1:0];
      end
    end
  end

  assign w_transfer = (r_state == IDLE) && !i_cancel && w_found;

  always_comb begin
    o_req_ready = '0;
    if (w_transfer) begin
      o_req_ready[w_winner] = 1'b1;
    end
  end

  assign w_in_color  = i_req_color[w_winner*COLOR_W +: COLOR_W];
  assign w_in_dur    = i_req_dur[w_winner*DUR_BITS +: DUR_BITS];
  assign w_tick_wrap = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // cancel takes priority over the normal end-of-display exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_transfer) w_state_next = SHOW;
      SHOW: if (i_cancel || (w_tick_wrap && (r_remaining == DUR_BITS'(1)))) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty      <= '0;
      r_remaining <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_tick_cnt  <= '0;
    end else if (w_transfer) begin
      r_duty      <= w_in_color;
      r_remaining <= (w_in_dur == '0) ? DUR_BITS'(1) : w_in_dur;
      r_owner     <= w_winner;
      r_rr_ptr    <= (w_winner == OWN_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      r_tick_cnt  <= '0;
    end else if (r_state == SHOW) begin
      if (w_tick_wrap) begin
        r_tick_cnt <= '0;
        if (r_remaining != DUR_BITS'(1)) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  // The PWM stage registers its outputs, so feed it next-cycle enable and duty.
  assign w_en_next   = (w_state_next == SHOW);
  assign w_duty_next = w_transfer ? w_in_color : r_duty;

  rgb_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_en_next),
    .i_clr    (w_transfer),
    .i_duty_r (PWM_BITS'(w_duty_next.r)),
    .i_duty_g (PWM_BITS'(w_duty_next.g)),
    .i_duty_b (PWM_BITS'(w_duty_next.b)),
    .o_pwm_r  (o_pwm_red),
    .o_pwm_g  (o_pwm_green),
    .o_pwm_b  (o_pwm_blue)
  );

  assign o_busy  = (r_state == SHOW);
  assign o_owner = r_owner;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed self-checking bench for rgb_led_arbiter with a 4-cycle tick.
module tb_rgb_led_arbiter;

  localparam int NREQ = 4;
  localparam int TDIV = 4;
  localparam int DURW = 16;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] reqValid;
  logic [NREQ-1:0] reqReady;
  logic [NREQ*24-1:0]   reqColor;
  logic [NREQ*DURW-1:0] reqDur;
  logic            cancel;
  logic            pwmRed;
  logic            pwmGreen;
  logic            pwmBlue;
  logic            busy;
  logic [1:0]      owner;

  int errors = 0;
  int checks = 0;

  rgb_led_arbiter #(
    .NUM_REQ  (NREQ),
    .PWM_BITS (8),
    .TICK_DIV (TDIV),
    .DUR_BITS (DURW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_color (reqColor),
    .i_req_dur   (reqDur),
    .i_cancel    (cancel),
    .o_pwm_red   (pwmRed),
    .o_pwm_green (pwmGreen),
    .o_pwm_blue  (pwmBlue),
    .o_busy      (busy),
    .o_owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setReq(input int idx, input logic [23:0] col, input logic [15:0] dur);
    reqColor[idx*24 +: 24]     = col;
    reqDur[idx*DURW +: DURW]   = dur;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    reqValid = '0;
    cancel   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts remaining busy cycles from the current cycle; lands on the first idle cycle.
  task automatic countBusy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    reqValid = '0;
    cancel   = 1'b0;
    reqColor = '0;
    reqDur   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    checks++;
    if ({pwmRed, pwmGreen, pwmBlue} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_pwm: got %b expected 000", {pwmRed, pwmGreen, pwmBlue});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", reqReady); end
  endtask

  task automatic test_single_request();
    int n;
    setReq(0, 24'h8000FF, 16'd3);
    reqValid = 4'b0001;
    #1;
    checks++;
    if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0001", reqReady); end
    @(negedge clk);
    reqValid = '0;
    checks++;
    if (owner !== 2'd0) begin errors++; $display("[TB] FAIL single_owner: got %0d expected 0", owner); end
    for (int k = 0; k < 3 * TDIV; k++) begin
      checks++;
      if ({busy, pwmRed, pwmGreen, pwmBlue} !== 4'b1101) begin
        errors++;
        $display("[TB] FAIL single_cycle%0d: got busy/r/g/b %b expected 1101", k, {busy, pwmRed, pwmGreen, pwmBlue});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, pwmRed, pwmGreen, pwmBlue} !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_end: got busy/r/g/b %b expected 0000", {busy, pwmRed, pwmGreen, pwmBlue});
    end
    n = 0;
    countBusy(n);
  endtask

  task automatic test_pwm_pattern();
    int badR, badG, badB, badBusy;
    logic expR, expB;
    badR = 0; badG = 0; badB = 0; badBusy = 0;
    doReset();
    setReq(0, 24'h8000FF, 16'd70);
    reqValid = 4'b0001;
    @(negedge clk);
    reqValid = '0;
    reqColor = '0;
    reqDur   = '0;
    for (int k = 0; k < 70 * TDIV; k++) begin
      expR = ((k % 256) < 128);
      expB = ((k % 256) < 255);
      if (pwmRed !== expR) badR++;
      if (pwmGreen !== 1'b0) badG++;
      if (pwmBlue !== expB) badB++;
      if (busy !== 1'b1) badBusy++;
      @(negedge clk);
    end
    checks++;
    if (badR != 0) begin errors++; $display("[TB] FAIL pwm_red_pattern: got %0d bad cycles expected 0", badR); end
    checks++;
    if (badG != 0) begin errors++; $display("[TB] FAIL pwm_green_pattern: got %0d bad cycles expected 0", badG); end
    checks++;
    if (badB != 0) begin errors++; $display("[TB] FAIL pwm_blue_pattern: got %0d bad cycles expected 0", badB); end
    checks++;
    if (badBusy != 0) begin errors++; $display("[TB] FAIL pwm_busy_window: got %0d bad cycles expected 0", badBusy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pwm_window_end: got busy %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int n;
    int exp;
    doReset();
    for (int i = 0; i < NREQ; i++) setReq(i, 24'h101010 * (i + 1), 16'd1);
    reqValid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = g % NREQ;
      #1;
      checks++;
      if (reqReady !== 4'(1 << exp) || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL rr_ready%0d: got ready %b busy %b expected %b busy 0", g, reqReady, busy, 4'(1 << exp));
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || owner !== 2'(exp)) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got busy %b owner %0d expected busy 1 owner %0d", g, busy, owner, exp);
      end
      countBusy(n);
      checks++;
      if (n != TDIV) begin errors++; $display("[TB] FAIL rr_len%0d: got %0d cycles expected %0d", g, n, TDIV); end
    end
    reqValid = '0;
  endtask

  task automatic test_zero_duration();
    int n;
    doReset();
    setReq(1, 24'h123456, 16'd0);
    reqValid = 4'b0010;
    #1;
    checks++;
    if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL zero_ready: got %b expected 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    countBusy(n);
    checks++;
    if (n != TDIV) begin errors++; $display("[TB] FAIL zero_len: got %0d cycles expected %0d", n, TDIV); end
  endtask

  task automatic test_cancel();
    int n;
    doReset();
    setReq(0, 24'hFFFFFF, 16'd5);
    reqValid = 4'b0001;
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pwmRed, pwmGreen, pwmBlue} !== 4'b0000) begin
      errors++; $display("[TB] FAIL cancel_mid: got busy/r/g/b %b expected 0000", {busy, pwmRed, pwmGreen, pwmBlue});
    end
    setReq(1, 24'h00FF00, 16'd2);
    reqValid = 4'b0010;
    #1;
    checks++;
    if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL cancel_idle_ready: got %b expected 0000", reqReady); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_holds_idle: got busy %b expected 0", busy); end
    cancel = 1'b0;
    #1;
    checks++;
    if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL cancel_release_ready: got %b expected 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    repeat (2 * TDIV - 1) @(negedge clk);
    checks++;
    if ({busy, pwmGreen} !== 2'b11) begin
      errors++; $display("[TB] FAIL cancel_last_tick_busy: got busy/g %b expected 11", {busy, pwmGreen});
    end
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pwmRed, pwmGreen, pwmBlue} !== 4'b0000) begin
      errors++; $display("[TB] FAIL cancel_final: got busy/r/g/b %b expected 0000", {busy, pwmRed, pwmGreen, pwmBlue});
    end
    cancel = 1'b0;
    countBusy(n);
  endtask

  task automatic test_reset_mid_show();
    int n;
    doReset();
    setReq(2, 24'h0000FF, 16'd5);
    setReq(1, 24'h00FF00, 16'd1);
    setReq(3, 24'hFF0000, 16'd1);
    reqValid = 4'b0100;
    @(negedge clk);
    checks++;
    if (owner !== 2'd2) begin errors++; $display("[TB] FAIL rstshow_owner: got %0d expected 2", owner); end
    reqValid = 4'b1010;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pwmRed, pwmGreen, pwmBlue, owner} !== 6'b0) begin
      errors++; $display("[TB] FAIL rstshow_outputs: got busy/r/g/b/owner %b expected 000000", {busy, pwmRed, pwmGreen, pwmBlue, owner});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL rstshow_rearb: got %b expected 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    checks++;
    if (owner !== 2'd1) begin errors++; $display("[TB] FAIL rstshow_grant: got %0d expected 1", owner); end
    countBusy(n);
  endtask

  task automatic test_priority_rotation();
    int n;
    doReset();
    setReq(1, 24'h000011, 16'd1);
    setReq(2, 24'h000022, 16'd1);
    setReq(3, 24'h000033, 16'd1);
    reqValid = 4'b0100;
    @(negedge clk);
    reqValid = 4'b1010;
    countBusy(n);
    #1;
    checks++;
    if (reqReady !== 4'b1000) begin errors++; $display("[TB] FAIL rot_first: got %b expected 1000", reqReady); end
    @(negedge clk);
    checks++;
    if (owner !== 2'd3) begin errors++; $display("[TB] FAIL rot_owner3: got %0d expected 3", owner); end
    countBusy(n);
    #1;
    checks++;
    if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL rot_second: got %b expected 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    checks++;
    if (owner !== 2'd1) begin errors++; $display("[TB] FAIL rot_owner1: got %0d expected 1", owner); end
    countBusy(n);
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_pwm_pattern();
    test_round_robin();
    test_zero_duration();
    test_cancel();
    test_reset_mid_show();
    test_priority_rotation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
